type_handle_allocator: RTL and testbench
========================================

// Module: type_handle_allocator
// PURPOSE
//   Hardware object factory. Issues unique handles from a fixed pool to NUM_CH requesters.
//   Records the requested type ID per handle, and takes handles back on release.
//   Sits between traffic agents/DUT-side models and any block that maps handle -> type.
//   Generalises the single-client factory to N channels with round-robin fairness,
//   occupancy tracking and free-list error detection.
// PARAMETERS
//   NUM_CH       4    number of requesting channels (>=1)
//   NUM_HANDLES  16   size of the handle pool (>=2)
//   TYPE_W       8    width of the type ID stored per handle
// PORTS
//   clk            in   1                       single clock, rising edge
//   rst            in   1                       asynchronous, active-high reset
//   req_valid      in   NUM_CH                  per-channel allocation request
//   req_type       in   NUM_CH*TYPE_W           per-channel requested type ID
//   req_ready      out  NUM_CH                  per-channel grant (one-hot or zero)
//   alloc_valid    out  1                       allocation result valid (1-cycle pulse)
//   alloc_ch       out  $clog2(NUM_CH)          channel that was served
//   alloc_handle   out  $clog2(NUM_HANDLES)     handle issued
//   rel_valid      in   1                       release request
//   rel_handle     in   $clog2(NUM_HANDLES)     handle to release
//   err_bad_free   out  1                       pulse: released handle was not allocated
//   lookup_handle  in   $clog2(NUM_HANDLES)     combinational type lookup address
//   lookup_type    out  TYPE_W                  type ID stored for lookup_handle
//   lookup_live    out  1                       lookup_handle is currently allocated
//   used_count     out  $clog2(NUM_HANDLES+1)   number of handles allocated
//   full           out  1                       used_count == NUM_HANDLES
// BEHAVIOUR
//   - Reset (async assert, sync deassert by the system): used bitmap = 0, rr pointer = 0,
//     type table = 0.
//     alloc_valid/err_bad_free/used_count = 0; full = 0; req_ready = 0 while rst is high.
//   - Handshake: a request transfers when req_valid[c] && req_ready[c].
//     req_ready is combinational from req_valid, the rr pointer and full.
//     At most one bit is set per cycle.
//     Requester holds req_valid/req_type stable until ready.
//   - Arbitration: round-robin starting at rr pointer. After a grant to channel c the pointer
//     becomes (c+1) mod NUM_CH. The pointer is unchanged when there is no grant.
//   - Handle choice: lowest-index free bit of the used bitmap as registered at the start of
//     the cycle.
//   - Latency: grant in cycle N. In cycle N+1: alloc_valid=1, alloc_ch, alloc_handle.
//     Used bit is set, type table entry is written.
//     No backpressure on the result.
//   - Full: when all handles are used, req_ready = 0 for all channels; requests stall, none
//     are dropped.
//   - Release: if rel_valid and the handle is live, the used bit clears at the next edge.
//     Otherwise err_bad_free pulses 1 cycle later and state is unchanged.
//     The type entry is kept (not cleared) on release.
//   - Simultaneous grant + release in the same cycle:
//     - The grant uses the pre-release bitmap, so a just-released handle is not reissued
//       in that cycle.
//     - used_count nets +1 -1 = unchanged.
//     - A release arriving while full does not enable a grant until the next cycle.
//   - used_count: +1 on grant, -1 on valid release, never wraps. full = (used_count == NUM_HANDLES).
//   - Lookup is combinational. lookup_type and lookup_live reflect registered state only;
//     there is no bypass of same-cycle writes.
//   - rst asserted mid-operation: any pending result is discarded (alloc_valid=0 next
//     cycle) and all handles return to free.
// STRUCTURE
//   - Package type_alloc_pkg:
//     - handle_t and type_id_t typedefs.
//     - alloc_result_t struct {ch, handle}.
//     - HANDLE_W and CH_W localparam functions.
//   - Sub-module rr_arbiter #(N): req[N], ptr -> one-hot gnt[N] plus encoded index.
//     It is reused elsewhere.
//   - The remainder (bitmap, priority encoder, type table, counter) lives in this module.
// TESTING (defaults NUM_CH=4, NUM_HANDLES=16, TYPE_W=8)
//   1. Post-reset, ch0 requests type 0x2A:
//      -> req_ready=0001; next cycle alloc_valid=1, ch=0, handle=0; used_count=1;
//         lookup(0)=0x2A live=1.
//   2. All 4 channels request continuously for 4 cycles:
//      -> grants ch0,1,2,3 in order; handles 0,1,2,3; rr pointer back to 0.
//   3. Fill 16 handles, then ch2 requests:
//      -> full=1, req_ready=0000 held. Then release handle 5:
//      -> next cycle grant; alloc_handle=5.
//   4. Release handle 3 while ch1 is granted in the same cycle (used={0..7}):
//      -> ch1 receives handle 8, not 3; used_count stays 8.
//   5. Release a never-allocated handle 9 and a double-free of 2:
//      -> err_bad_free pulses each time; used_count unchanged.
//   6. Assert rst for 1 cycle while ch3 is granted:
//      -> alloc_valid=0 afterwards, used_count=0, full=0, lookup_live(any)=0.

Source files
------------

// File: rtl/type_handle_allocator_pkg.sv
//------------------------------------------------------------------------------
// Module : type_alloc_pkg
// Brief  : Shared types and width helpers for the type handle allocator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package type_alloc_pkg;

    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_NUM_HANDLES = 16;
    localparam int DEF_TYPE_W      = 8;

    // Index widths never drop to zero, so a single channel still gets a 1-bit field.
    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int calc_handle_w(input int num_handles);
        return (num_handles > 1) ? $clog2(num_handles) : 1;
    endfunction

    localparam int CH_W     = calc_ch_w(DEF_NUM_CH);
    localparam int HANDLE_W = calc_handle_w(DEF_NUM_HANDLES);

    typedef logic [HANDLE_W-1:0]   handle_t;
    typedef logic [DEF_TYPE_W-1:0] type_id_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        handle_t         handle;
    } alloc_result_t;

endpackage

`default_nettype wire

// File: rtl/type_handle_allocator_if.sv
//------------------------------------------------------------------------------
// Module : type_handle_allocator_if
// Brief  : Request/result/release/lookup bundle of the type handle allocator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface type_handle_allocator_if
    import type_alloc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int NUM_HANDLES = 16,
    parameter int TYPE_W      = 8
);
    localparam int CW    = calc_ch_w(NUM_CH);
    localparam int HW    = calc_handle_w(NUM_HANDLES);
    localparam int CNT_W = $clog2(NUM_HANDLES + 1);

    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*TYPE_W-1:0] req_type;
    logic [NUM_CH-1:0]        req_ready;
    logic                     alloc_valid;
    logic [CW-1:0]            alloc_ch;
    logic [HW-1:0]            alloc_handle;
    logic                     rel_valid;
    logic [HW-1:0]            rel_handle;
    logic                     err_bad_free;
    logic [HW-1:0]            lookup_handle;
    logic [TYPE_W-1:0]        lookup_type;
    logic                     lookup_live;
    logic [CNT_W-1:0]         used_count;
    logic                     full;

    modport master (
        output req_valid, req_type, rel_valid, rel_handle, lookup_handle,
        input  req_ready, alloc_valid, alloc_ch, alloc_handle, err_bad_free,
               lookup_type, lookup_live, used_count, full
    );

    modport slave (
        input  req_valid, req_type, rel_valid, rel_handle, lookup_handle,
        output req_ready, alloc_valid, alloc_ch, alloc_handle, err_bad_free,
               lookup_type, lookup_live, used_count, full
    );

endinterface

`default_nettype wire

// File: rtl/type_handle_allocator_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module : rr_arbiter
// Brief  : Combinational round-robin arbiter; search starts at ptr.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int w_c;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        w_c = 0;
        for (int i = 0; i < N; i++) begin
            w_c = (int'(ptr) + i) % N;
            if (!any && req[w_c]) begin
                gnt[w_c] = 1'b1;
                idx      = IDX_W'(w_c);
                any      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/type_handle_allocator.sv
//------------------------------------------------------------------------------
// Module : type_handle_allocator
// Brief  : N-channel handle pool with per-handle type table and release checks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module type_handle_allocator
    import type_alloc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int NUM_HANDLES = 16,
    parameter int TYPE_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    type_handle_allocator_if.slave  bus
);

    localparam int CW    = calc_ch_w(NUM_CH);
    localparam int HW    = calc_handle_w(NUM_HANDLES);
    localparam int CNT_W = $clog2(NUM_HANDLES + 1);

    logic [NUM_HANDLES-1:0] r_used;
    logic [CW-1:0]          r_ptr;
    logic [TYPE_W-1:0]      r_types [NUM_HANDLES];
    logic [CNT_W-1:0]       r_count;
    logic                   r_alloc_valid;
    logic [CW-1:0]          r_alloc_ch;
    logic [HW-1:0]          r_alloc_handle;
    logic                   r_err;

    logic                   w_full;
    logic [NUM_CH-1:0]      w_req;
    logic [NUM_CH-1:0]      w_gnt;
    logic [CW-1:0]          w_gnt_idx;
    logic                   w_grant;
    logic [HW-1:0]          w_free_idx;
    logic [(2**HW)-1:0]     w_used_ext;
    logic                   w_rel_ok;
    logic [NUM_HANDLES-1:0] w_used_nxt;

    assign w_full = (r_count == CNT_W'(NUM_HANDLES));
    // Requests are masked while full or in reset so req_ready drops immediately.
    assign w_req  = bus.req_valid & {NUM_CH{~w_full & ~rst}};

    rr_arbiter #(.N(NUM_CH), .IDX_W(CW)) u_arb (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_gnt_idx),
        .any (w_grant)
    );

    always_comb begin
        w_free_idx = '0;
        for (int i = NUM_HANDLES - 1; i >= 0; i--) begin
            if (!r_used[i]) w_free_idx = HW'(i);
        end
    end

    // Bitmap widened to the full handle address space so out-of-pool handles read as free.
    always_comb begin
        w_used_ext                = '0;
        w_used_ext[NUM_HANDLES-1:0] = r_used;
    end

    assign w_rel_ok = bus.rel_valid & w_used_ext[bus.rel_handle];

    always_comb begin
        w_used_nxt = r_used;
        if (w_grant)  w_used_nxt[w_free_idx]     = 1'b1;
        if (w_rel_ok) w_used_nxt[bus.rel_handle] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used         <= '0;
            r_ptr          <= '0;
            r_count        <= '0;
            r_alloc_valid  <= 1'b0;
            r_alloc_ch     <= '0;
            r_alloc_handle <= '0;
            r_err          <= 1'b0;
            for (int i = 0; i < NUM_HANDLES; i++) r_types[i] <= '0;
        end else begin
            r_used         <= w_used_nxt;
            r_alloc_valid  <= w_grant;
            r_alloc_ch     <= w_gnt_idx;
            r_alloc_handle <= w_free_idx;
            r_err          <= bus.rel_valid & ~w_rel_ok;
            if (w_grant) begin
                r_types[w_free_idx] <= bus.req_type[w_gnt_idx*TYPE_W +: TYPE_W];
                r_ptr <= (w_gnt_idx == CW'(NUM_CH - 1)) ? '0 : w_gnt_idx + CW'(1);
            end
            if (w_grant && !w_rel_ok)      r_count <= r_count + CNT_W'(1);
            else if (!w_grant && w_rel_ok) r_count <= r_count - CNT_W'(1);
        end
    end

    assign bus.req_ready    = w_gnt;
    assign bus.alloc_valid  = r_alloc_valid;
    assign bus.alloc_ch     = r_alloc_ch;
    assign bus.alloc_handle = r_alloc_handle;
    assign bus.err_bad_free = r_err;
    assign bus.lookup_type  = r_types[bus.lookup_handle];
    assign bus.lookup_live  = w_used_ext[bus.lookup_handle];
    assign bus.used_count   = r_count;
    assign bus.full         = w_full;

endmodule

`default_nettype wire

// File: tb/tb_type_handle_allocator.sv
//------------------------------------------------------------------------------
// Module : tb_type_handle_allocator
// Brief  : Directed self-checking bench for type_handle_allocator.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_type_handle_allocator;
    import type_alloc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    type_handle_allocator_if #(.NUM_CH(4), .NUM_HANDLES(16), .TYPE_W(8)) bus ();

    type_handle_allocator #(.NUM_CH(4), .NUM_HANDLES(16), .TYPE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid     = '0;
        bus.req_type      = '0;
        bus.rel_valid     = 1'b0;
        bus.rel_handle    = '0;
        bus.lookup_handle = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic [7:0] t);
        bus.req_valid[ch]        = 1'b1;
        bus.req_type[ch*8 +: 8]  = t;
    endtask

    task automatic release_handle(input logic [3:0] h);
        bus.rel_valid  = 1'b1;
        bus.rel_handle = h;
        tick();
        bus.rel_valid  = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state, with requests pending to show req_ready is held low
        rst = 1'b1;
        idle_inputs();
        bus.req_valid = 4'b1111;
        tick();
        #1;
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_alloc_valid", bus.alloc_valid, 1'b0);
        check("rst_used_count", bus.used_count, 0);
        check("rst_full", bus.full, 1'b0);
        check("rst_err", bus.err_bad_free, 1'b0);
        bus.req_valid = '0;
        tick();
        rst = 1'b0;

        // 1: single request from ch0
        set_req(0, 8'h2A);
        #1;
        check("t1_ready", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        bus.lookup_handle = 4'd0;
        #1;
        check("t1_alloc_valid", bus.alloc_valid, 1'b1);
        check("t1_alloc_ch", bus.alloc_ch, 0);
        check("t1_alloc_handle", bus.alloc_handle, 0);
        check("t1_used_count", bus.used_count, 1);
        check("t1_lookup_type", bus.lookup_type, 8'h2A);
        check("t1_lookup_live", bus.lookup_live, 1'b1);

        // 2: four channels contend, round-robin order
        do_reset();
        for (int c = 0; c < 4; c++) set_req(c, 8'h10 + 8'(c));
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_ready", bus.req_ready, 32'(1 << k));
            tick();
            check("t2_alloc_ch", bus.alloc_ch, k);
            check("t2_alloc_handle", bus.alloc_handle, k);
        end
        #1;
        check("t2_ptr_wrap_ready", bus.req_ready, 4'b0001);
        tick();
        check("t2_h4", bus.alloc_handle, 4);

        // 3: fill the pool, stall while full, release 5 and reuse it
        bus.req_valid = 4'b0001;
        for (int h = 5; h < 16; h++) begin
            tick();
            check("t3_fill_handle", bus.alloc_handle, h);
        end
        check("t3_full", bus.full, 1'b1);
        check("t3_used_count", bus.used_count, 16);
        bus.req_valid = 4'b0000;
        set_req(2, 8'h77);
        #1;
        check("t3_ready_full", bus.req_ready, 4'b0000);
        tick();
        check("t3_no_alloc", bus.alloc_valid, 1'b0);
        check("t3_ready_held", bus.req_ready, 4'b0000);
        bus.rel_valid  = 1'b1;
        bus.rel_handle = 4'd5;
        #1;
        check("t3_ready_rel_while_full", bus.req_ready, 4'b0000);
        tick();
        bus.rel_valid = 1'b0;
        #1;
        check("t3_count_after_rel", bus.used_count, 15);
        check("t3_not_full", bus.full, 1'b0);
        check("t3_ready_after_rel", bus.req_ready, 4'b0100);
        check("t3_no_alloc_yet", bus.alloc_valid, 1'b0);
        tick();
        bus.req_valid = '0;
        bus.lookup_handle = 4'd5;
        #1;
        check("t3_alloc_valid", bus.alloc_valid, 1'b1);
        check("t3_alloc_ch", bus.alloc_ch, 2);
        check("t3_alloc_handle", bus.alloc_handle, 5);
        check("t3_refull", bus.full, 1'b1);
        check("t3_lookup_type", bus.lookup_type, 8'h77);

        // 4: grant and release in the same cycle
        do_reset();
        set_req(0, 8'h01);
        for (int h = 0; h < 8; h++) tick();
        bus.req_valid = '0;
        set_req(1, 8'h55);
        bus.rel_valid  = 1'b1;
        bus.rel_handle = 4'd3;
        #1;
        check("t4_ready", bus.req_ready, 4'b0010);
        tick();
        bus.rel_valid = 1'b0;
        bus.req_valid = '0;
        bus.lookup_handle = 4'd3;
        #1;
        check("t4_alloc_ch", bus.alloc_ch, 1);
        check("t4_alloc_handle", bus.alloc_handle, 8);
        check("t4_used_count", bus.used_count, 8);
        check("t4_h3_live", bus.lookup_live, 1'b0);
        check("t4_h3_type_kept", bus.lookup_type, 8'h01);
        bus.lookup_handle = 4'd8;
        #1;
        check("t4_h8_live", bus.lookup_live, 1'b1);
        check("t4_h8_type", bus.lookup_type, 8'h55);

        // 5: bad frees
        release_handle(4'd9);
        check("t5_err_never_alloc", bus.err_bad_free, 1'b1);
        check("t5_count_a", bus.used_count, 8);
        tick();
        check("t5_err_pulse_end", bus.err_bad_free, 1'b0);
        release_handle(4'd2);
        check("t5_err_good_free", bus.err_bad_free, 1'b0);
        check("t5_count_b", bus.used_count, 7);
        release_handle(4'd2);
        check("t5_err_double_free", bus.err_bad_free, 1'b1);
        check("t5_count_c", bus.used_count, 7);

        // 6: reset while ch3 is being granted
        set_req(3, 8'h3C);
        #1;
        check("t6_ready", bus.req_ready, 4'b1000);
        rst = 1'b1;
        #1;
        check("t6_ready_in_rst", bus.req_ready, 4'b0000);
        tick();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        check("t6_alloc_valid", bus.alloc_valid, 1'b0);
        check("t6_used_count", bus.used_count, 0);
        check("t6_full", bus.full, 1'b0);
        for (int h = 0; h < 16; h++) begin
            bus.lookup_handle = 4'(h);
            #1;
            check("t6_lookup_live", bus.lookup_live, 1'b0);
        end
        tick();
        check("t6_alloc_valid_later", bus.alloc_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
